ram16_access_arbiter: RTL and testbench
=======================================

// Module: ram16_access_arbiter
// PURPOSE
//  Shares one RAM16 (16 words x 16 bits) between two requester ports (P0, P1) using a req/ack handshake.
//  Sequences each access as a one-cycle RAM enable, then captures read data and acknowledges.
//  Sits directly in front of RAM16 and drives its en/rw/address/in; takes RAM16 out back.
// PARAMETERS
//  DATA_W  16  data width; must match RAM16 word width
//  ADDR_W  4   address width; must match RAM16 depth (2**ADDR_W = 16)
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       reset, synchronous, active-high
//  req0/req1  in   1       access request from P0/P1; held high until ackN
//  rw0/rw1    in   1       1 = write, 0 = read; stable while reqN high
//  addr0/1    in   ADDR_W  word address; stable while reqN high
//  wdata0/1   in   DATA_W  write data; stable while reqN high
//  ack0/ack1  out  1       one-cycle completion pulse to P0/P1
//  rdata0/1   out  DATA_W  read data for P0/P1; valid with ackN, held until next read by that port
//  ram_en     out  1       RAM16 en
//  ram_rw     out  1       RAM16 rw (1 = write)
//  ram_addr   out  ADDR_W  RAM16 address
//  ram_wdata  out  DATA_W  RAM16 in
//  ram_rdata  in   DATA_W  RAM16 out
//  busy       out  1       high in ACCESS and RESP
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; ram_en, ram_rw, ram_addr, ram_wdata, ack0, ack1, busy = 0;
//    rdata0 = rdata1 = 0; last_grant = 1 (P0 favoured first). Reset wins over all other events.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. All outputs registered or decoded from state only.
//  - IDLE: if any reqN high, pick winner (see arbitration), latch grant id, rw, addr, wdata; go ACCESS.
//    No req: stay IDLE, ram_en = 0.
//  - ACCESS (1 cycle): ram_en=1, ram_rw/addr/wdata = latched values; busy=1; go RESP.
//  - RESP (1 cycle): ram_en=0; ackN=1 for granted port only; if read, rdataN <= ram_rdata
//    (RAM16 data is valid the cycle after en); write leaves rdataN unchanged; last_grant <= N; go IDLE.
//  - Latency: req high at edge k (in IDLE) -> ram_en high cycle k+1 -> ack high cycle k+2.
//    Throughput: one access per 3 cycles; IDLE always entered between accesses.
//  - Requester must drop reqN on the edge where it samples ackN=1; req seen in IDLE is always new.
//  - Non-granted request stays pending; its fields are not sampled until it is granted.
//  - ram_addr/ram_wdata/ram_rw hold last driven value outside ACCESS (ram_en=0 there).
//  - Request dropped before grant: ignored, no ack. Request dropped after grant: access completes, ack still pulses.
//  - ack0 and ack1 never high together; at most one ram_en cycle per grant.
//  - Reset mid ACCESS/RESP: access aborted, no ack issued; a write in ACCESS may or may not have reached RAM.
// CONFIGURATION
//  RAM16_ARB_ROUND_ROBIN_EN
//  - Defined: on simultaneous req0 & req1, grant the port != last_grant (strict alternation under contention).
//  - Undefined: fixed priority, P0 always wins contention; last_grant still tracked but unused; P1 may starve.
//  - Single requester: granted immediately in both builds.
// TESTING
//  1. Reset, then req0 rw0=1 addr0=4'h3 wdata0=16'hBEEF; then req0 read addr 3 -> ram_en 1 cycle each,
//     ack0 at k+2, rdata0=16'hBEEF.
//  2. P1 writes 16'h1234 to addr 4'hF, P0 reads addr 4'hF -> rdata0=16'h1234; rdata1 unchanged (0).
//  3. req0 and req1 held high continuously, each re-requesting after ack (ROUND_ROBIN_EN defined)
//     -> grants P0,P1,P0,P1; acks 3 cycles apart.
//  4. Same stimulus, macro undefined -> P0 granted every time; ack1 never asserted while req0 kept high.
//  5. rst asserted in ACCESS cycle of a read -> next cycle all outputs 0, state IDLE, no ack; pending req re-served after rst drops.
//  6. Read to addr 0 after reset with no prior write -> ack with RAM16 reset content; ram_rw=0 during ram_en.

Source files
------------

// File: rtl/ram16_access_arbiter.sv
// Two-port req/ack arbiter in front of a single-port RAM16; sequences IDLE -> ACCESS -> RESP per access.
// Build option: define RAM16_ARB_ROUND_ROBIN_EN for alternating grants under contention (default: P0 priority).
module ram16_access_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              rw0_i,
    input  logic              rw1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              ram_en_o,
    output logic              ram_rw_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration and field capture happen here
    // ACCESS | one-cycle RAM enable with the captured rw/addr/wdata
    // RESP   | ack to the granted port; read data taken from RAM output
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                contend_pick;
    logic                winner;

`ifdef RAM16_ARB_ROUND_ROBIN_EN
    assign contend_pick = ~last_grant_q;
`else
    assign contend_pick = 1'b0;
`endif

    assign winner = (req0_i && req1_i) ? contend_pick : req1_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_rw_d     = ram_rw_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d     = ACCESS;
                    grant_d     = winner;
                    ram_rw_d    = winner ? rw1_i    : rw0_i;
                    ram_addr_d  = winner ? addr1_i  : addr0_i;
                    ram_wdata_d = winner ? wdata1_i : wdata0_i;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d      = IDLE;
                last_grant_d = grant_q;
                if (!ram_rw_q) begin
                    if (grant_q) rdata1_d = ram_rdata_i;
                    else         rdata0_d = ram_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_en_o    = (state_q == ACCESS);
    assign busy_o      = (state_q != IDLE);
    assign ack0_o      = (state_q == RESP) && !grant_q;
    assign ack1_o      = (state_q == RESP) &&  grant_q;
    assign ram_rw_o    = ram_rw_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

    // RAM output is only valid during RESP, so forward it there to make rdata valid alongside ack.
    assign rdata0_o = (ack0_o && !ram_rw_q) ? ram_rdata_i : rdata0_q;
    assign rdata1_o = (ack1_o && !ram_rw_q) ? ram_rdata_i : rdata1_q;

endmodule

// File: tb/tb_ram16_access_arbiter.sv
// Bench for ram16_access_arbiter: behavioural RAM16, transaction-level memory/arbitration model.
module tb_ram16_access_arbiter;

`ifdef RAM16_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req0, req1, rw0, rw1;
    logic [3:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, ram_en, ram_rw, busy;
    logic [15:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [3:0]  ram_addr;
    logic        ram_clear;
    logic [15:0] ram_mem [16];

    logic [15:0] mem_ref [16];
    logic [15:0] exp_rd [2];
    int          last_ref;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    ram16_access_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1), .rw0_i(rw0), .rw1_i(rw1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .ram_en_o(ram_en), .ram_rw_o(ram_rw), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
    );

    // RAM16: registered read, data valid the cycle after en.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 16'h0;
            ram_rdata <= 16'h0;
        end else if (ram_en) begin
            if (ram_rw) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic rw, input logic [3:0] a, input logic [15:0] d);
        if (p == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_ref = 1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
    endtask

    // Observes the bus until an ack appears or the budget runs out (ack_port stays -1).
    task automatic wait_ack(input int max_ticks, output int ticks, output int ack_port,
                            output int en_cnt, output int both_ack, output logic en_rw,
                            output logic [3:0] en_addr, output logic [15:0] en_wdata,
                            output logic [15:0] ack_rdata);
        ticks = 0; ack_port = -1; en_cnt = 0; both_ack = 0;
        en_rw = 1'bx; en_addr = 4'hx; en_wdata = 16'hx; ack_rdata = 16'hx;
        while (ack_port < 0 && ticks < max_ticks) begin
            tick();
            ticks++;
            if (ram_en) begin
                en_cnt++; en_rw = ram_rw; en_addr = ram_addr; en_wdata = ram_wdata;
            end
            if (ack0 && ack1) both_ack = 1;
            if (ack0)      begin ack_port = 0; ack_rdata = rdata0; end
            else if (ack1) begin ack_port = 1; ack_rdata = rdata1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_total++;
        if ({ack0, ack1, ram_en, ram_rw, busy} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, ram_en, ram_rw, busy});
        else n_pass++;
        n_total++;
        if ({ram_addr, ram_wdata, rdata0, rdata1} !== 52'h0) $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_wdata, rdata0, rdata1});
        else n_pass++;
        rst = 1'b0;
        last_ref = 1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
    endtask

    task automatic test_read_unwritten();
        int t, p, ne, b; logic r; logic [3:0] a; logic [15:0] w, d;
        issue(0, 1'b0, 4'h0, 16'hFFFF);
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (t !== 2 || p !== 0 || ne !== 1) $display("FAIL rd0_timing: got ticks=%0d port=%0d en=%0d expected 2 0 1", t, p, ne);
        else n_pass++;
        n_total++;
        if (r !== 1'b0 || a !== 4'h0) $display("FAIL rd0_bus: got rw=%b addr=%h expected 0 0", r, a);
        else n_pass++;
        n_total++;
        if (d !== mem_ref[0]) $display("FAIL rd0_data: got %h expected %h", d, mem_ref[0]);
        else n_pass++;
        exp_rd[0] = mem_ref[0]; last_ref = 0;
        drop(0); tick();
    endtask

    task automatic test_write_read();
        int t, p, ne, b; logic r; logic [3:0] a; logic [15:0] w, d;
        issue(0, 1'b1, 4'h3, 16'hBEEF);
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (t !== 2 || p !== 0 || ne !== 1) $display("FAIL wr_timing: got ticks=%0d port=%0d en=%0d expected 2 0 1", t, p, ne);
        else n_pass++;
        n_total++;
        if ({r, a, w} !== {1'b1, 4'h3, 16'hBEEF}) $display("FAIL wr_bus: got rw=%b addr=%h wdata=%h expected 1 3 beef", r, a, w);
        else n_pass++;
        mem_ref[3] = 16'hBEEF; last_ref = 0;
        drop(0); tick();
        issue(0, 1'b0, 4'h3, 16'h0);
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (t !== 2 || p !== 0 || ne !== 1 || r !== 1'b0) $display("FAIL rd_timing: got ticks=%0d port=%0d en=%0d rw=%b expected 2 0 1 0", t, p, ne, r);
        else n_pass++;
        n_total++;
        if (d !== 16'hBEEF) $display("FAIL rd_data: got %h expected beef", d);
        else n_pass++;
        exp_rd[0] = 16'hBEEF;
        drop(0); tick();
        n_total++;
        if (rdata0 !== 16'hBEEF || busy !== 1'b0) $display("FAIL rd_hold: got rdata0=%h busy=%b expected beef 0", rdata0, busy);
        else n_pass++;
    endtask

    task automatic test_cross_port();
        int t, p, ne, b; logic r; logic [3:0] a; logic [15:0] w, d;
        issue(1, 1'b1, 4'hF, 16'h1234);
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (t !== 2 || p !== 1 || {r, a, w} !== {1'b1, 4'hF, 16'h1234}) $display("FAIL p1_write: got ticks=%0d port=%0d bus=%h expected 2 1 1f1234", t, p, {r, a, w});
        else n_pass++;
        mem_ref[15] = 16'h1234; last_ref = 1;
        drop(1); tick();
        issue(0, 1'b0, 4'hF, 16'h0);
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (p !== 0 || d !== 16'h1234) $display("FAIL p0_read_f: got port=%0d data=%h expected 0 1234", p, d);
        else n_pass++;
        n_total++;
        if (rdata1 !== exp_rd[1]) $display("FAIL p1_rdata_unchanged: got %h expected %h", rdata1, exp_rd[1]);
        else n_pass++;
        exp_rd[0] = 16'h1234; last_ref = 0;
        drop(0); tick();
    endtask

    task automatic test_contention();
        int t, p, ne, b, exp_p;
        logic r; logic [3:0] a; logic [15:0] w, d;
        apply_reset();
        issue(0, 1'b0, 4'h3, 16'h0);
        issue(1, 1'b0, 4'hF, 16'h0);
        for (int k = 0; k < 4; k++) begin
            exp_p = RR ? 1 - last_ref : 0;
            wait_ack(10, t, p, ne, b, r, a, w, d);
            n_total++;
            if (p !== exp_p || b !== 0 || ne !== 1) $display("FAIL contend_grant%0d: got port=%0d both=%0d en=%0d expected %0d 0 1", k, p, b, ne, exp_p);
            else n_pass++;
            n_total++;
            if (t !== (k == 0 ? 2 : 3)) $display("FAIL contend_gap%0d: got %0d expected %0d", k, t, (k == 0 ? 2 : 3));
            else n_pass++;
            n_total++;
            if (d !== mem_ref[exp_p == 0 ? 3 : 15]) $display("FAIL contend_data%0d: got %h expected %h", k, d, mem_ref[exp_p == 0 ? 3 : 15]);
            else n_pass++;
            last_ref = exp_p;
            exp_rd[exp_p] = mem_ref[exp_p == 0 ? 3 : 15];
        end
        drop(0); drop(1);
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        int t, p, ne, b; logic r; logic [3:0] a; logic [15:0] w, d;
        issue(1, 1'b0, 4'hF, 16'h0);
        tick();
        n_total++;
        if (ram_en !== 1'b1) $display("FAIL mid_access_en: got %b expected 1", ram_en);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({ack0, ack1, ram_en, ram_rw, busy, ram_addr, ram_wdata, rdata0, rdata1} !== 57'h0)
            $display("FAIL mid_reset_outputs: got %h expected 0", {ack0, ack1, ram_en, ram_rw, busy, ram_addr, ram_wdata, rdata0, rdata1});
        else n_pass++;
        rst = 1'b0;
        last_ref = 1; exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        wait_ack(8, t, p, ne, b, r, a, w, d);
        n_total++;
        if (t !== 2 || p !== 1 || d !== mem_ref[15]) $display("FAIL mid_reset_reserve: got ticks=%0d port=%0d data=%h expected 2 1 %h", t, p, d, mem_ref[15]);
        else n_pass++;
        exp_rd[1] = mem_ref[15]; last_ref = 1;
        drop(1); tick();
    endtask

    task automatic test_random();
        int t, p, ne, b, win;
        logic r; logic [3:0] a; logic [15:0] w, d;
        bit pend [2];
        logic prw [2]; logic [3:0] pad [2]; logic [15:0] pwd [2];
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int q = 0; q < 2; q++)
                if (!pend[q] && $urandom_range(0, 2) != 0) begin
                    pend[q] = 1; prw[q] = 1'($urandom_range(0, 1));
                    pad[q] = 4'($urandom_range(0, 15)); pwd[q] = 16'($urandom);
                    issue(q, prw[q], pad[q], pwd[q]);
                end
            if (!pend[0] && !pend[1]) begin
                win = $urandom_range(0, 1);
                pend[win] = 1; prw[win] = 1'b0; pad[win] = 4'($urandom_range(0, 15)); pwd[win] = 16'($urandom);
                issue(win, prw[win], pad[win], pwd[win]);
            end
            win = (pend[0] && pend[1]) ? (RR ? 1 - last_ref : 0) : (pend[1] ? 1 : 0);
            wait_ack(8, t, p, ne, b, r, a, w, d);
            n_total++;
            if (t !== 2 || p !== win || ne !== 1 || b !== 0)
                $display("FAIL rand%0d_grant: got ticks=%0d port=%0d en=%0d both=%0d expected 2 %0d 1 0", it, t, p, ne, b, win);
            else n_pass++;
            n_total++;
            if (r !== prw[win] || a !== pad[win] || (prw[win] && w !== pwd[win]))
                $display("FAIL rand%0d_bus: got rw=%b addr=%h wdata=%h expected %b %h %h", it, r, a, w, prw[win], pad[win], pwd[win]);
            else n_pass++;
            if (prw[win]) mem_ref[pad[win]] = pwd[win];
            else          exp_rd[win] = mem_ref[pad[win]];
            n_total++;
            if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1])
                $display("FAIL rand%0d_rdata: got %h %h expected %h %h", it, rdata0, rdata1, exp_rd[0], exp_rd[1]);
            else n_pass++;
            last_ref = win;
            pend[win] = 0;
            drop(win);
            tick();
        end
        drop(0); drop(1);
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b1; ram_clear = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        for (int i = 0; i < 16; i++) mem_ref[i] = 16'h0;
        tick();
        ram_clear = 1'b0;
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_cross_port();
        test_contention();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
